regfile_wb_ctrl: RTL

- Write-back controller for the core's register file (one write port, two read ports).
- Arbitrates two write-back sources (EXU result, LSU load result) onto the single write port using round-robin with valid/ready handshakes.
- Registers the selected write and tracks pending destinations in a scoreboard.
- Reports read-after-write hazards for the two decode read addresses; decode stalls on them.

---
 rtl/regfile_wb_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
//
// Write-back controller for a register file with one write port and two
// read ports. Two write-back sources (EXU result and LSU load data) share
// the single write port through a round-robin arbiter with valid/ready
// handshakes. The granted write is registered one cycle before it reaches
// the register file. A scoreboard tracks destinations with an outstanding
// write. It produces read-after-write hazard flags for decode. It also
// refuses a new issue to a destination that is still pending.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   issue_valid/rd/ready      decode issue of an instruction writing issue_rd
//   exu_valid/rd/data/ready   EXU write-back request and grant
//   lsu_valid/rd/data/ready   LSU write-back request and grant
//   rf_wen/waddr/wdata        register file write port (registered)
//   raddr1, raddr2            decode read addresses
//   hazard1, hazard2          read address has a pending write
//   busy_vec                  scoreboard, bit i = register i pending
module regfile_wb_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     issue_valid,
    input  logic [ADDR_WIDTH-1:0]    issue_rd,
    output logic                     issue_ready,

    input  logic                     exu_valid,
    input  logic [ADDR_WIDTH-1:0]    exu_rd,
    input  logic [DATA_WIDTH-1:0]    exu_data,
    output logic                     exu_ready,

    input  logic                     lsu_valid,
    input  logic [ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     lsu_ready,

    output logic                     rf_wen,
    output logic [ADDR_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,

    input  logic [ADDR_WIDTH-1:0]    raddr1,
    input  logic [ADDR_WIDTH-1:0]    raddr2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic [2**ADDR_WIDTH-1:0] busy_vec
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    // Round-robin pointer: which source wins when both request.
    typedef enum logic {
        PRI_EXU = 1'b0,
        PRI_LSU = 1'b1
    } prio_t;

    prio_t                  prio_q;
    prio_t                  prio_d;

    logic                   exu_gnt;
    logic                   lsu_gnt;
    logic                   wb_fire;
    logic [ADDR_WIDTH-1:0]  wb_rd;
    logic [DATA_WIDTH-1:0]  wb_data;

    logic [NUM_REGS-1:0]    busy_q;
    logic [NUM_REGS-1:0]    busy_d;
    logic                   issue_fire;

    // ------------------------------------------------------------------
    // Arbiter: pointer register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PRI_EXU;
        end else begin
            prio_q <= prio_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbiter: grant and next pointer
    // A grant always completes a handshake because grant implies valid.
    // Nothing is granted while rst is high.
    // ------------------------------------------------------------------
    always_comb begin
        exu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        prio_d  = prio_q;

        if (!rst) begin
            if (exu_valid && (!lsu_valid || (prio_q == PRI_EXU))) begin
                exu_gnt = 1'b1;
            end else if (lsu_valid) begin
                lsu_gnt = 1'b1;
            end
        end

        if (exu_gnt) begin
            prio_d = PRI_LSU;
        end else if (lsu_gnt) begin
            prio_d = PRI_EXU;
        end
    end

    assign exu_ready = exu_gnt;
    assign lsu_ready = lsu_gnt;
    assign wb_fire   = exu_gnt | lsu_gnt;
    assign wb_rd     = lsu_gnt ? lsu_rd   : exu_rd;
    assign wb_data   = lsu_gnt ? lsu_data : exu_data;

    // ------------------------------------------------------------------
    // Output stage: one cycle between handshake and register file write.
    // An x0 write-back is still accepted but never raises rf_wen.
    // Address and data hold when idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (wb_fire) begin
            rf_wen   <= (wb_rd != '0);
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    assign issue_ready = !rst && ((issue_rd == '0) || !busy_q[issue_rd]);
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

    // A bit clears on the same edge the register file commits, so it drops
    // exactly when the data becomes readable. The set is applied last so it
    // wins over a clear of the same index.
    always_comb begin
        busy_d = busy_q;
        if (rf_wen) begin
            busy_d[rf_waddr] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // ------------------------------------------------------------------
    // Hazards (no forwarding): x0 never reports a hazard
    // ------------------------------------------------------------------
    assign hazard1 = busy_q[raddr1] && (raddr1 != '0);
    assign hazard2 = busy_q[raddr2] && (raddr2 != '0);

endmodule
